string_receiver: RTL

Decoder for the single-wire LED string protocol that `string_driver` generates. It samples one `sdi` line, measures each high pulse to recover 24-bit pixels (MSB first), and flags the end of each frame when the latch (long low) period is seen. It is used as the on-chip loopback checker on `led_sdi[1]` and as the downstream monitor in string-level simulation.

---
 rtl/string_receiver.sv | 232 +++++++++++++++++++++++
 1 files changed

// File: rtl/string_receiver.sv
// string_receiver: decodes the single-wire LED string protocol.
// Each high pulse on sdi is measured in clock cycles. Short pulses are zeros,
// long pulses are ones, and 24 bits (MSB first) form one pixel. A long low
// period ends the frame and reports how many complete pixels it contained.
//
// Build option: define STRING_RECEIVER_GLITCH_FILTER_EN to add a 3-sample
// stability filter after the synchroniser. Without it, 1- and 2-cycle highs
// are reported on bit_err. With it, they are ignored.
//
// FSM: SYNC -> IDLE -> HIGH <-> LOW. Any error returns to SYNC, which waits
// for a full latch-length low before pixels are decoded again.
module string_receiver #(
  parameter int CLK_PERIOD_NS = 50,
  parameter int HIGH_MIN_NS   = 150,
  parameter int BIT_THRESH_NS = 600,
  parameter int HIGH_MAX_NS   = 1000,
  parameter int LATCH_NS      = 50000,
  parameter int COUNT_WIDTH   = 12
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   sdi,
  output logic [23:0]            pixel_data,
  output logic                   pixel_data_valid,
  output logic                   frame_end,
  output logic [COUNT_WIDTH-1:0] pixel_count,
  output logic                   bit_err,
  output logic                   busy
);

  // Timing thresholds in clock cycles (integer division of the ns values).
  localparam int HIGH_MIN   = HIGH_MIN_NS / CLK_PERIOD_NS;
  localparam int BIT_THRESH = BIT_THRESH_NS / CLK_PERIOD_NS;
  localparam int HIGH_MAX   = HIGH_MAX_NS / CLK_PERIOD_NS;
  localparam int LATCH      = LATCH_NS / CLK_PERIOD_NS;

  // The width counter only needs to reach the longest threshold (the latch).
  localparam int WIDTH_W = $clog2(LATCH + 1);

  localparam logic [WIDTH_W-1:0] HIGH_MIN_W   = WIDTH_W'(HIGH_MIN);
  localparam logic [WIDTH_W-1:0] BIT_THRESH_W = WIDTH_W'(BIT_THRESH);
  localparam logic [WIDTH_W-1:0] HIGH_MAX_W   = WIDTH_W'(HIGH_MAX);
  localparam logic [WIDTH_W-1:0] LATCH_W      = WIDTH_W'(LATCH);

  localparam logic [COUNT_WIDTH-1:0] COUNT_MAX = {COUNT_WIDTH{1'b1}};

  typedef enum logic [1:0] {
    ST_SYNC = 2'd0,
    ST_IDLE = 2'd1,
    ST_HIGH = 2'd2,
    ST_LOW  = 2'd3
  } state_t;

  state_t               state;
  logic                 sync_1;
  logic                 sync_2;
  logic                 line;
  logic                 line_prev;
  logic                 rise;
  logic                 fall;
  logic [WIDTH_W-1:0]   width_cnt;
  logic [4:0]           bit_cnt;
  // Holds the first 23 bits of a pixel; the 24th bit goes straight into
  // pixel_data together with these.
  logic [22:0]          shift;
  logic [COUNT_WIDTH-1:0] frame_cnt;
  logic                 new_bit;

  // Two-flop synchroniser for the asynchronous serial input.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_1 <= 1'b0;
      sync_2 <= 1'b0;
    end else begin
      sync_1 <= sdi;
      sync_2 <= sync_1;
    end
  end

`ifdef STRING_RECEIVER_GLITCH_FILTER_EN
  logic hist_1;
  logic hist_2;
  logic filt_q;

  // Sample history and held filter output; the line only moves once three
  // consecutive synchronised samples agree, so both edges of a pulse are
  // delayed equally and its measured width is preserved.
  always_ff @(posedge clk) begin
    if (reset) begin
      hist_1 <= 1'b0;
      hist_2 <= 1'b0;
      filt_q <= 1'b0;
    end else begin
      hist_1 <= sync_2;
      hist_2 <= hist_1;
      filt_q <= line;
    end
  end

  assign line = ((sync_2 == hist_1) && (hist_1 == hist_2)) ? sync_2 : filt_q;
`else
  assign line = sync_2;
`endif

  // Registered copy of the line for edge detection.
  always_ff @(posedge clk) begin
    if (reset) begin
      line_prev <= 1'b0;
    end else begin
      line_prev <= line;
    end
  end

  assign rise = line & ~line_prev;
  assign fall = ~line & line_prev;

  // Length of the current level. The edge cycle is the first cycle of the new
  // level, so the counter restarts at 1 and equals the completed width when
  // the following edge arrives. Saturates at the latch length.
  always_ff @(posedge clk) begin
    if (reset) begin
      width_cnt <= '0;
    end else if (rise || fall) begin
      width_cnt <= WIDTH_W'(1);
    end else if (width_cnt < LATCH_W) begin
      width_cnt <= width_cnt + 1'b1;
    end
  end

  // Decoded bit value of a high pulse that is ending now.
  assign new_bit = (width_cnt >= BIT_THRESH_W);

  // Protocol FSM with registered outputs; pulses default low every cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      state            <= ST_SYNC;
      bit_cnt          <= '0;
      shift            <= '0;
      frame_cnt        <= '0;
      pixel_data       <= '0;
      pixel_data_valid <= 1'b0;
      frame_end        <= 1'b0;
      pixel_count      <= '0;
      bit_err          <= 1'b0;
      busy             <= 1'b0;
    end else begin
      pixel_data_valid <= 1'b0;
      frame_end        <= 1'b0;
      bit_err          <= 1'b0;

      case (state)
        // Wait for a full latch-length low. A rise that arrives right as the
        // low completes is the start of a real pulse, so it is not dropped.
        ST_SYNC: begin
          if (!line_prev && (width_cnt >= LATCH_W)) begin
            if (rise) begin
              state <= ST_HIGH;
              busy  <= 1'b1;
            end else begin
              state <= ST_IDLE;
            end
          end
        end

        ST_IDLE: begin
          if (rise) begin
            state <= ST_HIGH;
            busy  <= 1'b1;
          end
        end

        ST_HIGH: begin
          if (width_cnt >= HIGH_MAX_W) begin
            // Line held high too long: abandon the pixel and resynchronise.
            bit_err <= 1'b1;
            bit_cnt <= '0;
            state   <= ST_SYNC;
            busy    <= 1'b0;
          end else if (fall) begin
            if (width_cnt < HIGH_MIN_W) begin
              // Glitch: discard the partial pixel and resynchronise.
              bit_err <= 1'b1;
              bit_cnt <= '0;
              state   <= ST_SYNC;
              busy    <= 1'b0;
            end else begin
              shift <= {shift[21:0], new_bit};
              if (bit_cnt == 5'd23) begin
                pixel_data       <= {shift, new_bit};
                pixel_data_valid <= 1'b1;
                bit_cnt          <= '0;
                if (frame_cnt != COUNT_MAX) begin
                  frame_cnt <= frame_cnt + 1'b1;
                end
              end else begin
                bit_cnt <= bit_cnt + 5'd1;
              end
              state <= ST_LOW;
            end
          end
        end

        ST_LOW: begin
          if (width_cnt >= LATCH_W) begin
            // Latch seen: publish the frame and report any dangling bits.
            frame_end   <= 1'b1;
            pixel_count <= frame_cnt;
            frame_cnt   <= '0;
            bit_cnt     <= '0;
            if (bit_cnt != 5'd0) begin
              bit_err <= 1'b1;
            end
            if (rise) begin
              state <= ST_HIGH;
            end else begin
              state <= ST_IDLE;
              busy  <= 1'b0;
            end
          end else if (rise) begin
            state <= ST_HIGH;
          end
        end

        default: begin
          state <= ST_SYNC;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
